// File: rtl/adc_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_tx_pkg
//  Description : Shared types and constants for the ADC LVDS transmit emulator.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_tx_pkg;

    typedef enum logic [1:0] {
        PAT_FIFO   = 2'b00,
        PAT_RAMP   = 2'b01,
        PAT_CUSTOM = 2'b10,
        PAT_DESKEW = 2'b11
    } pattern_e;

    localparam int          FRAME_BITS  = 8;
    localparam int          LANES       = 2;
    localparam int          WORD_W      = FRAME_BITS * LANES;
    localparam logic [15:0] DESKEW_WORD = 16'hCCCC;

endpackage
`default_nettype wire

// File: rtl/adc_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : adc_tx_fifo
//  Description : Small synchronous FIFO holding samples awaiting transmission.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_tx_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (c_AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr[c_AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/adc_lvds_tx_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : adc_lvds_tx_emulator
//  Description : Serialises samples onto two LVDS-style lanes plus frame clock,
//                with test patterns and frame-slip injection.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_lvds_tx_emulator
    import adc_tx_pkg::*;
#(
    parameter int         RES_BITS    = 14,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] FCO_PATTERN = 8'hF0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic [RES_BITS-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [1:0]          pattern_sel,
    input  logic [15:0]         custom_word,
    input  logic                fco_slip,
    output logic                d0,
    output logic                d1,
    output logic                fco,
    output logic                frame_start,
    output logic                underflow
);

    localparam int c_CNT_W = $clog2(FRAME_BITS);
    localparam int c_SHIFT = WORD_W - RES_BITS;
    localparam logic [c_CNT_W-1:0] c_LAST_K = c_CNT_W'(FRAME_BITS - 1);

    logic [c_CNT_W-1:0]  r_k;
    logic                r_ins;
    logic [WORD_W-1:0]   r_word;
    logic [RES_BITS-1:0] r_ramp;
    logic [WORD_W-1:0]   r_last_word;
    logic                r_slip_pend;

    logic [RES_BITS-1:0] w_fifo_rdata;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_load;
    logic                w_underflow;
    logic [WORD_W-1:0]   w_word;
    pattern_e            w_pat;

    assign s_ready     = ~w_fifo_full & ~RST;
    assign w_push      = s_valid & s_ready;
    assign w_pat       = pattern_e'(pattern_sel);
    assign w_load      = (r_k == '0) & ~r_ins & en;
    assign w_pop       = w_load & (w_pat == PAT_FIFO) & ~w_fifo_empty;
    assign w_underflow = w_load & (w_pat == PAT_FIFO) & w_fifo_empty;

    adc_tx_fifo #(
        .WIDTH (RES_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_wdata (s_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_word = '0;
        case (w_pat)
            PAT_FIFO:   w_word = w_fifo_empty ? r_last_word
                                              : (WORD_W'(w_fifo_rdata) << c_SHIFT);
            PAT_RAMP:   w_word = WORD_W'(r_ramp) << c_SHIFT;
            PAT_CUSTOM: w_word = custom_word;
            PAT_DESKEW: w_word = DESKEW_WORD;
            default:    w_word = '0;
        endcase
    end

    // With an 8-bit frame, {~k,1} is 15-2k and {~k,0} is 14-2k; ~k alone is 7-k.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_k         <= '0;
            r_ins       <= 1'b0;
            r_word      <= '0;
            r_ramp      <= '0;
            r_last_word <= '0;
            r_slip_pend <= 1'b0;
            d0          <= 1'b0;
            d1          <= 1'b0;
            fco         <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            r_slip_pend <= fco_slip | (r_slip_pend & ~r_ins);
            if (r_ins) begin
                // Inserted slip cycle: lanes and fco hold their bit-7 values.
                r_ins       <= 1'b0;
                frame_start <= 1'b0;
                underflow   <= 1'b0;
            end else if (r_k == '0) begin
                if (en) begin
                    r_word      <= w_word;
                    d1          <= w_word[WORD_W-1];
                    d0          <= w_word[WORD_W-2];
                    fco         <= FCO_PATTERN[FRAME_BITS-1];
                    frame_start <= 1'b1;
                    underflow   <= w_underflow;
                    r_k         <= c_CNT_W'(1);
                    if (w_pat == PAT_RAMP) r_ramp <= r_ramp + RES_BITS'(1);
                    if (w_pop) r_last_word <= w_word;
                end else begin
                    d1          <= 1'b0;
                    d0          <= 1'b0;
                    fco         <= 1'b0;
                    frame_start <= 1'b0;
                    underflow   <= 1'b0;
                end
            end else begin
                d1          <= r_word[{~r_k, 1'b1}];
                d0          <= r_word[{~r_k, 1'b0}];
                fco         <= FCO_PATTERN[~r_k];
                frame_start <= 1'b0;
                underflow   <= 1'b0;
                r_k         <= r_k + c_CNT_W'(1);
                if ((r_k == c_LAST_K) && r_slip_pend) r_ins <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/adc_lvds_tx_emulator.md
Name: adc_lvds_tx_emulator

Overview:
- Fabric-side transmitter that emulates the 2-lane-per-channel serial ADC output format, for loopback and bench stimulus of the ADC receive path.
- Accepts parallel samples through a valid/ready interface into a small FIFO.
- Serialises each sample over two data lanes, one bit per CLK cycle, 8 bits per lane per frame, alongside a frame clock.
- Test-pattern modes and a frame-slip injector exercise receiver alignment.

Parameters:
- RES_BITS, 14, sample resolution; samples are left-justified into the 16-bit frame word (word = s_data << (16-RES_BITS)).
- FIFO_DEPTH, 4, sample FIFO entries (power of two, >=2).
- FCO_PATTERN, 8'hF0, frame-clock bit pattern per frame, MSB transmitted first.

Ports:
- CLK  in  1  bit-rate clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- en  in  1  transmit enable.
- s_data  in  RES_BITS  sample input.
- s_valid  in  1  sample valid.
- s_ready  out  1  FIFO not full.
- pattern_sel  in  2  00 FIFO data, 01 ramp, 10 custom, 11 deskew.
- custom_word  in  16  word used in custom mode.
- fco_slip  in  1  request a one-bit frame phase slip.
- d0  out  1  even-bit lane.
- d1  out  1  odd-bit lane.
- fco  out  1  frame clock.
- frame_start  out  1  pulse coincident with bit 0 of each frame on the outputs.
- underflow  out  1  pulse: FIFO empty at load in mode 00.

Behaviour:
- Reset values: d0=d1=fco=0, frame_start=0, underflow=0, s_ready=0 while RST is high. FIFO emptied, bit counter k=0, ramp=0, last_word=0, slip_pending=0.
- FIFO: push when s_valid && s_ready; s_ready = !full. No full-with-pop bypass. Pops occur only at frame load.
- Frame: counter k runs 0..7. At k=0 the frame word W is loaded. pattern_sel is sampled at k=0 only; mid-frame changes take effect next frame.
  - Mode 00: pop FIFO → W. If the FIFO is empty, W = last_word and underflow pulses for 1 cycle.
  - Mode 01: W = ramp << (16-RES_BITS); ramp increments once per ramp frame and wraps from 2^RES_BITS-1 to 0.
  - Mode 10: W = custom_word.
  - Mode 11: W = 16'hCCCC, so each lane carries 10101010.
- Bit k drives d1 = W[15-2k], d0 = W[14-2k], fco = FCO_PATTERN[7-k]. The MSB pair goes out first.
- All outputs are registered: bit k appears one cycle after counter state k. frame_start is high with bit 0.
- Latency: a sample pushed into an empty FIFO is sent at the next k=0 load. Its first bit appears 1 cycle after that load.
- en=0: the counter holds at k=0 and outputs are 0. The FIFO still accepts data until full. When en rises, the first frame loads on that cycle. en is sampled only at k=0; a frame already in progress completes.
- Slip: fco_slip sets slip_pending on any cycle. At k=7 with slip_pending set, one extra cycle is inserted that repeats the bit-7 outputs, then slip_pending clears. Multiple requests within one frame collapse to a single slip. A request arriving in the insert cycle applies to the next frame.
- Reset mid-frame aborts the frame immediately with the reset values above; FIFO contents are discarded.

Decomposition:
- Package adc_tx_pkg:
  - pattern_sel enum (PAT_FIFO, PAT_RAMP, PAT_CUSTOM, PAT_DESKEW).
  - Constants FRAME_BITS=8, LANES=2, WORD_W=16, DESKEW_WORD=16'hCCCC.
- One sub-module, adc_tx_fifo: synchronous FIFO with push/pop/full/empty on CLK/RST.
- Frame counter, pattern mux, slip logic and output registers stay in the top.

Test Plan:
- RES_BITS=14, mode 00, push 14'h2ABC (W=16'hAAF0) → d1 = 11111100, d0 = 00001100, fco = 11110000, frame_start on bit 0.
- Mode 00 with FIFO empty after pushing 14'h1234 → next frame repeats word 16'h48D0 and underflow pulses once at load.
- Mode 01 over 16386 frames → words decode as 0,1,…,16383,0,1; no gaps.
- Mode 11 → both lanes 10101010 every frame. Switching to mode 10 with custom_word=16'hFF00 mid-frame → the current frame is unchanged; the next frame has d1=d0=11110000.
- fco_slip pulsed twice within one frame → exactly one 9-cycle frame, all later frames shifted by 1 bit. fco keeps a 4-high/4-low shape except the repeated bit-7 cycle, where fco stays low (5 consecutive lows).
- Push 5 samples with FIFO_DEPTH=4 and en=0 → s_ready drops after the 4th. Assert RST mid-frame → outputs 0 the next cycle, FIFO empty, ramp=0.
